cordic_vector_engine: RTL

CORDIC_VECTOR_ENGINE -- requirements
Module: cordic_vector_engine

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_atan_rom.sv | 31 +++
 rtl/cordic_vector_engine.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC vectoring engine.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int unsigned PHASE_W  = 32;
    localparam int unsigned MAX_ITER = 16;
    localparam int unsigned IDX_W    = $clog2(MAX_ITER);

    // Fractional guard bits carried below the integer LSB of x/y.
    localparam int unsigned FRAC_W   = 12;

    localparam logic signed [PHASE_W-1:0] PI_Q29      = 32'sh6487ED51;
    localparam logic signed [PHASE_W-1:0] HALF_PI_Q29 = 32'sh3243F6A9;

endpackage

// File: rtl/cordic_atan_rom.sv
// Elementary angle table: atan(2^-k) in Q3.29, rounded to nearest.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [IDX_W-1:0]   i_idx,
    output logic [PHASE_W-1:0] o_atan_c
);

    always_comb begin
        o_atan_c = '0;
        case (i_idx)
            4'd0:  o_atan_c = 32'h1921FB54;
            4'd1:  o_atan_c = 32'h0ED63383;
            4'd2:  o_atan_c = 32'h07D6DD7E;
            4'd3:  o_atan_c = 32'h03FAB753;
            4'd4:  o_atan_c = 32'h01FF55BB;
            4'd5:  o_atan_c = 32'h00FFEAAE;
            4'd6:  o_atan_c = 32'h007FFD55;
            4'd7:  o_atan_c = 32'h003FFFAB;
            4'd8:  o_atan_c = 32'h001FFFF5;
            4'd9:  o_atan_c = 32'h000FFFFF;
            4'd10: o_atan_c = 32'h00080000;
            4'd11: o_atan_c = 32'h00040000;
            4'd12: o_atan_c = 32'h00020000;
            4'd13: o_atan_c = 32'h00010000;
            4'd14: o_atan_c = 32'h00008000;
            4'd15: o_atan_c = 32'h00004000;
        endcase
    end

endmodule

// File: rtl/cordic_vector_engine.sv
// Iterative CORDIC vectoring engine: one micro-rotation per cycle, producing
// magnitude (with CORDIC gain) and atan2 phase for a complex I/Q sample.
module cordic_vector_engine
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ITER   = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_i,
    input  logic signed [DATA_W-1:0]  in_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W+1:0]         out_mag,
    output logic signed [PHASE_W-1:0] out_phase
);

    localparam int unsigned EXT_W = DATA_W + 2;
    localparam int unsigned XW    = EXT_W + FRAC_W;
    localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(ITER - 1);
    localparam logic [XW-1:0]    MAG_HALF = XW'(1) << (FRAC_W - 1);

    state_t                    r_state,     w_state_nxt;
    logic                      r_live;
    logic signed [XW-1:0]      r_x,         w_x_nxt;
    logic signed [XW-1:0]      r_y,         w_y_nxt;
    logic signed [PHASE_W-1:0] r_z,         w_z_nxt;
    logic [IDX_W-1:0]          r_k,         w_k_nxt;
    logic                      r_zero,      w_zero_nxt;
    logic                      r_out_valid, w_out_valid_nxt;
    logic [EXT_W-1:0]          r_mag,       w_mag_nxt;
    logic signed [PHASE_W-1:0] r_phase,     w_phase_nxt;

    logic signed [XW-1:0]      w_i_ext;
    logic signed [XW-1:0]      w_q_ext;
    logic signed [XW-1:0]      w_x_shr;
    logic signed [XW-1:0]      w_y_shr;
    logic signed [XW-1:0]      w_x_rot;
    logic signed [XW-1:0]      w_y_rot;
    logic signed [PHASE_W-1:0] w_z_rot;
    logic [PHASE_W-1:0]        w_atan;
    logic                      w_accept;

    cordic_atan_rom u_atan_rom (
        .i_idx    (r_k),
        .o_atan_c (w_atan)
    );

    assign w_i_ext = {{2{in_i[DATA_W-1]}}, in_i, {FRAC_W{1'b0}}};
    assign w_q_ext = {{2{in_q[DATA_W-1]}}, in_q, {FRAC_W{1'b0}}};

    // r_live keeps in_ready low until the first edge after reset release.
    assign in_ready = r_live && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_mag   = r_mag;
    assign out_phase = r_phase;

    assign w_x_shr = r_x >>> r_k;
    assign w_y_shr = r_y >>> r_k;

    // One micro-rotation driving y toward zero, using pre-update x and y.
    always_comb begin
        if (!r_y[XW-1]) begin
            w_x_rot = r_x + w_y_shr;
            w_y_rot = r_y - w_x_shr;
            w_z_rot = r_z + $signed(w_atan);
        end else begin
            w_x_rot = r_x - w_y_shr;
            w_y_rot = r_y + w_x_shr;
            w_z_rot = r_z - $signed(w_atan);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_z_nxt         = r_z;
        w_k_nxt         = r_k;
        w_zero_nxt      = r_zero;
        w_out_valid_nxt = r_out_valid;
        w_mag_nxt       = r_mag;
        w_phase_nxt     = r_phase;

        case (r_state)
            ST_ROTATE: begin
                w_x_nxt = w_x_rot;
                w_y_nxt = w_y_rot;
                w_z_nxt = w_z_rot;
                w_k_nxt = r_k + IDX_W'(1);
                if (r_k == LAST_K) begin
                    w_state_nxt     = ST_DONE;
                    w_out_valid_nxt = 1'b1;
                    w_mag_nxt       = r_zero ? '0 :
                        EXT_W'(($unsigned(w_x_rot) + MAG_HALF) >> FRAC_W);
                    w_phase_nxt     = r_zero ? '0 : w_z_rot;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Quadrant pre-rotation folds the left half-plane onto the right.
        if (w_accept) begin
            w_state_nxt = ST_ROTATE;
            w_k_nxt     = '0;
            w_zero_nxt  = (in_i == '0) && (in_q == '0);
            if (in_i[DATA_W-1]) begin
                w_x_nxt = -w_i_ext;
                w_y_nxt = -w_q_ext;
                w_z_nxt = in_q[DATA_W-1] ? -PI_Q29 : PI_Q29;
            end else begin
                w_x_nxt = w_i_ext;
                w_y_nxt = w_q_ext;
                w_z_nxt = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_k         <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_mag       <= '0;
            r_phase     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_live      <= 1'b1;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_z         <= w_z_nxt;
            r_k         <= w_k_nxt;
            r_zero      <= w_zero_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_mag       <= w_mag_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

endmodule
